// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//
// Serial stimulus transmitter for the Mealy sequence detectors. A start request
// in IDLE latches a bit pattern, a length and a repeat count. The pattern is
// then sent MSB-first, one bit per clock, for rep+1 back-to-back passes. An
// overlapping "101" hit counter runs over the emitted stream so that a bench
// can compare it directly against a detector's out pulses.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-low reset (0 = reset)
//   start    in   begin a transmission; honoured only in IDLE
//   pattern  in   [WIDTH-1:0] bit pattern; bit [len-1] is sent first, bit [0] last
//   len      in   [LEN_W-1:0] bits per pass; 0 is rejected, >WIDTH clamps to WIDTH
//   rep      in   [REP_W-1:0] extra passes (total = rep+1). The name is rep
//                 rather than repeat because repeat is a reserved word.
//   out      out  serial data bit; 0 whenever valid is 0
//   valid    out  out carries a pattern bit this cycle
//   busy     out  high in SEND and DONE
//   done     out  one-cycle pulse in the cycle after the last bit
//   err      out  one-cycle pulse when a start is rejected because len == 0
//   hit_cnt  out  [HIT_W-1:0] saturating overlapping "101" count
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] rep,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;      // pattern latched at acceptance
  logic [IDX_W-1:0] last_idx;   // index of the first bit of each pass (len-1)
  logic [IDX_W-1:0] idx;        // index of the bit currently on out
  logic [REP_W-1:0] rep_left;   // passes still to go after the current one
  logic [1:0]       hist;       // two previously emitted bits, newest in [0]

  logic [LEN_W-1:0] len_eff;
  logic [IDX_W-1:0] start_idx;
  logic             hit;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise the tool infers a latch to hold the old value.
  always_comb begin
    len_eff   = (len > WIDTH_L) ? WIDTH_L : len;
    // Only used when len != 0, so the wrap at len == 0 is harmless.
    start_idx = IDX_W'(len_eff - LEN_W'(1));
  end

  // out is the bit being emitted this cycle; together with the two earlier
  // bits it completes a "101" match.
  assign hit = (hist == 2'b10) && out;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the reset is synchronous, so it lives inside the clocked branch
      // and the sensitivity list holds only the clock edge.
      state    <= IDLE;
      out      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      hit_cnt  <= '0;
      hist     <= '0;
      pat_q    <= '0;
      last_idx <= '0;
      idx      <= '0;
      rep_left <= '0;
    end else begin
      // Pulses default low and are raised only in the cycle they apply to.
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              err <= 1'b1;
            end else begin
              pat_q    <= pattern;
              last_idx <= start_idx;
              idx      <= start_idx;
              rep_left <= rep;
              hist     <= '0;
              hit_cnt  <= '0;
              // First bit goes out in the very next cycle.
              out      <= pattern[start_idx];
              valid    <= 1'b1;
              busy     <= 1'b1;
              state    <= SEND;
            end
          end
        end

        SEND: begin
          hist <= {hist[0], out};
          if (hit && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + HIT_W'(1);
          end

          if (idx == '0) begin
            if (rep_left != '0) begin
              // Wrap straight into the next pass with no idle bit.
              rep_left <= rep_left - REP_W'(1);
              idx      <= last_idx;
              out      <= pat_q[last_idx];
            end else begin
              out   <= 1'b0;
              valid <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            idx <= idx - IDX_W'(1);
            out <= pat_q[idx - IDX_W'(1)];
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
//
// Directed bench for seq_pattern_gen. Two instances share the stimulus: dut
// uses the default HIT_W=8 and dut_sat uses HIT_W=2, so the saturating
// counter can be observed. Inputs change 1 time unit after the rising edge,
// and outputs are sampled at that same point, well away from the next edge.
// A small overlapping "101" detector in the bench watches out/valid and acts
// as the downstream Mealy detector.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rep;

  logic       out, valid, busy, done, err;
  logic [7:0] hit_cnt;

  logic       out_s, valid_s, busy_s, done_s, err_s;
  logic [1:0] hit_s;

  int compared   = 0;
  int mismatched = 0;

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4), .HIT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .rep     (rep),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .hit_cnt (hit_cnt)
  );

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4), .HIT_W(2)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .rep     (rep),
    .out     (out_s),
    .valid   (valid_s),
    .busy    (busy_s),
    .done    (done_s),
    .err     (err_s),
    .hit_cnt (hit_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction: start pulse, every emitted bit, the done cycle, and the
  // first IDLE cycle afterwards. Leaves the bench in that IDLE cycle, so a
  // following call exercises the earliest possible restart.
  task automatic send(input string tag, input logic [7:0] p, input logic [3:0] l,
                      input logic [3:0] r, input logic [63:0] exp_bits, input int n,
                      input int exp_hits, input int exp_det);
    logic [1:0] det_hist;
    int         det;
    int         exp_sat;
    det_hist = 2'b00;
    det      = 0;
    exp_sat  = (exp_hits > 3) ? 3 : exp_hits;

    pattern = p;
    len     = l;
    rep     = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;

    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(out), 32'(exp_bits[n-1-i]));
      check($sformatf("%s_valid%0d", tag, i), 32'(valid), 32'd1);
      if (valid) begin
        if ((det_hist == 2'b10) && out) det++;
        det_hist = {det_hist[0], out};
      end
      tick();
    end

    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_valid"}, 32'(valid), 32'd0);
    check({tag, "_done_out"}, 32'(out), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    check({tag, "_hits"}, 32'(hit_cnt), 32'(exp_hits));
    check({tag, "_hits_sat"}, 32'(hit_s), 32'(exp_sat));
    check({tag, "_detector"}, 32'(det), 32'(exp_det));
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_hits"}, 32'(hit_cnt), 32'(exp_hits));
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    len     = 4'd0;
    rep     = 4'd0;

    // Reset state
    tick();
    tick();
    check("rst_out",   32'(out),     32'd0);
    check("rst_valid", 32'(valid),   32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_err",   32'(err),     32'd0);
    check("rst_hits",  32'(hit_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Basic: 101 -> one hit
    send("basic", 8'b0000_0101, 4'd3, 4'd0, 64'b101, 3, 1, 1);

    // Overlap across a repetition boundary: 10101 10101 -> four hits
    send("overlap", 8'b0001_0101, 4'd5, 4'd1, 64'b10101_10101, 10, 4, 4);

    // len above WIDTH clamps to 8 bits: 10100101 -> two hits
    send("clamp", 8'hA5, 4'd12, 4'd0, 64'hA5, 8, 2, 2);

    // len == 0: rejected with an err pulse, no transmission, hit_cnt held
    pattern = 8'hFF;
    len     = 4'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("len0_err",   32'(err),     32'd1);
    check("len0_valid", 32'(valid),   32'd0);
    check("len0_busy",  32'(busy),    32'd0);
    check("len0_hits",  32'(hit_cnt), 32'd2);
    tick();
    check("len0_err_clear", 32'(err),   32'd0);
    check("len0_valid2",    32'(valid), 32'd0);

    // start held high: first transaction at edge 0, second accepted only at
    // the first IDLE cycle (cycle 5); inputs changed mid-flight are ignored.
    pattern = 8'b0000_0101;
    len     = 4'd3;
    rep     = 4'd0;
    start   = 1'b1;
    tick();
    check("held_c1_out",   32'(out),   32'd1);
    tick();
    check("held_c2_out",   32'(out),   32'd0);
    check("held_c2_busy",  32'(busy),  32'd1);
    tick();
    check("held_c3_out",   32'(out),   32'd1);
    tick();
    check("held_c4_done",  32'(done),  32'd1);
    check("held_c4_hits",  32'(hit_cnt), 32'd1);
    tick();
    check("held_c5_valid", 32'(valid), 32'd0);
    check("held_c5_busy",  32'(busy),  32'd0);
    check("held_c5_hits",  32'(hit_cnt), 32'd1);
    tick();
    check("held_c6_valid", 32'(valid), 32'd1);
    check("held_c6_out",   32'(out),   32'd1);
    check("held_c6_hits",  32'(hit_cnt), 32'd0);
    pattern = 8'h00;
    len     = 4'd1;
    start   = 1'b0;
    tick();
    check("held_c7_out",   32'(out),   32'd0);
    check("held_c7_valid", 32'(valid), 32'd1);
    tick();
    check("held_c8_out",   32'(out),   32'd1);
    tick();
    check("held_c9_done",  32'(done),  32'd1);
    check("held_c9_hits",  32'(hit_cnt), 32'd1);
    tick();
    check("held_c10_busy", 32'(busy),  32'd0);

    // Reset in the middle of a transmission, held for two edges
    pattern = 8'hFF;
    len     = 4'd8;
    rep     = 4'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("mid_c1_out",   32'(out),   32'd1);
    check("mid_c1_valid", 32'(valid), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst1_out",   32'(out),     32'd0);
    check("mid_rst1_valid", 32'(valid),   32'd0);
    check("mid_rst1_busy",  32'(busy),    32'd0);
    check("mid_rst1_hits",  32'(hit_cnt), 32'd0);
    tick();
    check("mid_rst2_valid", 32'(valid), 32'd0);
    check("mid_rst2_busy",  32'(busy),  32'd0);
    check("mid_rst2_done",  32'(done),  32'd0);
    rst = 1'b1;
    tick();
    check("mid_rel_valid",  32'(valid), 32'd0);

    // Start one cycle after reset release is accepted normally
    send("post_rst", 8'b0000_0101, 4'd3, 4'd0, 64'b101, 3, 1, 1);

    // Saturation: 32 alternating bits -> 15 hits, HIT_W=2 instance stops at 3
    send("sat", 8'hAA, 4'd8, 4'd3, 64'hAAAA_AAAA, 32, 15, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
